// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, entry type and constants for the write-back unit.
package wb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int REG_AW   = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t with an age-ordered view of all entries.
//   clk, reset (async active-low)
//   push/din  : enqueue (ignored when full)
//   pop/dout  : dequeue head (ignored when empty)
//   full, empty, count : occupancy from registered state
//   ent[i]    : i-th oldest entry (ent[0] is the head); valid only for i < count
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t [DEPTH-1:0]    ent
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    // DEPTH is a power of two, so full is exactly the count MSB.
    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok)
            rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            ent[i] = mem_q[rd_ptr_q + AW'(i)];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and buffered load returns into one registered write port.
//   clk, reset (async active-low)
//   alu_valid/alu_rd/alu_data : single-cycle ALU results, always win arbitration
//   ld_valid/ld_ready/ld_rd/ld_data : load returns, buffered in wb_fifo
//   regWrite/writeReg/writeData : registered write to the register file
//   stall_req (FIFO full), pending (FIFO or output stage busy), fifo_count
//   byp_addr*/byp_hit*/byp_data* : forwarding of queued writes
// Build option: define WB_BYPASS_EN to build the bypass; otherwise hits/data are tied to 0.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = XLEN_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [4:0]                    ld_rd,
    input  logic [XLEN-1:0]               ld_data,
    output logic                          regWrite,
    output logic [4:0]                    writeReg,
    output logic [XLEN-1:0]               writeData,
    output logic                          stall_req,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic [4:0]                    byp_addr1,
    input  logic [4:0]                    byp_addr2,
    output logic                          byp_hit1,
    output logic                          byp_hit2,
    output logic [XLEN-1:0]               byp_data1,
    output logic [XLEN-1:0]               byp_data2
);
    logic                      wr_valid_q, wr_valid_d;
    logic [4:0]                wr_rd_q, wr_rd_d;
    logic [XLEN-1:0]           wr_data_q, wr_data_d;
    logic                      alu_issue, fifo_pop, fifo_push, fifo_full, fifo_empty;
    wb_entry_t                 fifo_din, fifo_head;
    wb_entry_t [FIFO_DEPTH-1:0] fifo_ent;

    // An rd=0 ALU result is dropped and leaves the slot free for a FIFO pop.
    assign alu_issue = alu_valid && alu_rd != REG_ZERO;
    assign fifo_pop  = !alu_issue && !fifo_empty;
    assign ld_ready  = !fifo_full;
    // rd=0 loads complete the handshake but are never stored.
    assign fifo_push = ld_valid && ld_ready && ld_rd != REG_ZERO;
    assign fifo_din  = '{rd: ld_rd, data: ld_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .ent   (fifo_ent)
    );

    always_comb begin
        wr_valid_d = alu_issue || fifo_pop;
        wr_rd_d    = alu_issue ? alu_rd   : fifo_pop ? fifo_head.rd   : wr_rd_q;
        wr_data_d  = alu_issue ? alu_data : fifo_pop ? fifo_head.data : wr_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_valid_q <= 1'b0;
            wr_rd_q    <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign regWrite  = wr_valid_q;
    assign writeReg  = wr_rd_q;
    assign writeData = wr_data_q;
    assign stall_req = fifo_full;
    assign pending   = !fifo_empty || wr_valid_q;

`ifdef WB_BYPASS_EN
    // Output stage is the oldest pending write; FIFO entries are scanned oldest
    // to youngest so the youngest match overrides.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        if (wr_valid_q && byp_addr1 != REG_ZERO && wr_rd_q == byp_addr1) begin
            byp_hit1  = 1'b1;
            byp_data1 = wr_data_q;
        end
        if (wr_valid_q && byp_addr2 != REG_ZERO && wr_rd_q == byp_addr2) begin
            byp_hit2  = 1'b1;
            byp_data2 = wr_data_q;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ($bits(fifo_count)'(i) < fifo_count) begin
                if (byp_addr1 != REG_ZERO && fifo_ent[i].rd == byp_addr1) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = fifo_ent[i].data;
                end
                if (byp_addr2 != REG_ZERO && fifo_ent[i].rd == byp_addr2) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = fifo_ent[i].data;
                end
            end
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{byp_addr1, byp_addr2, fifo_ent};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        stall_req;
    logic        pending;
    logic [2:0]  fifo_count;
    logic [4:0]  byp_addr1, byp_addr2;
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_writeback #(.FIFO_DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .stall_req(stall_req), .pending(pending), .fifo_count(fifo_count),
        .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        byp_addr1 = '0;   byp_addr2 = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #12;
        n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regWrite got %0h exp 0", regWrite); end
        n_tests++; if (writeReg !== 5'd0) begin n_fail++; $display("FAIL rst_writeReg got %0h exp 0", writeReg); end
        n_tests++; if (writeData !== 32'd0) begin n_fail++; $display("FAIL rst_writeData got %0h exp 0", writeData); end
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        n_tests++; if (pending !== 1'b0 || stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_pend_stall got %0b%0b exp 00", pending, stall_req); end
        n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ld_ready got %0h exp 1", ld_ready); end
        n_tests++; if (byp_hit1 !== 1'b0 || byp_data1 !== 32'd0) begin n_fail++; $display("FAIL rst_byp got %0b/%0h exp 0/0", byp_hit1, byp_data1); end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        step();
        n_tests++; if (regWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regWrite got %0h exp 1", regWrite); end
        n_tests++; if (writeReg !== 5'd5 || writeData !== 32'h1234) begin n_fail++; $display("FAIL alu_write got %0d/%0h exp 5/1234", writeReg, writeData); end
        alu_rd = 5'd0; alu_data = 32'h55;
        step();
        n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL alu_x0 got %0h exp 0", regWrite); end
        n_tests++; if (writeReg !== 5'd5 || writeData !== 32'h1234) begin n_fail++; $display("FAIL alu_hold got %0d/%0h exp 5/1234", writeReg, writeData); end
        idle();
        step();
    endtask

    task automatic test_load();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD;
        step();
        ld_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd1 || regWrite !== 1'b0) begin n_fail++; $display("FAIL ld_push got cnt=%0d we=%0b exp 1/0", fifo_count, regWrite); end
        step();
        n_tests++; if (regWrite !== 1'b1 || writeReg !== 5'd7 || writeData !== 32'hDEAD) begin n_fail++; $display("FAIL ld_write got %0b/%0d/%0h exp 1/7/dead", regWrite, writeReg, writeData); end
        n_tests++; if (fifo_count !== 3'd0 || pending !== 1'b1) begin n_fail++; $display("FAIL ld_pop got cnt=%0d pend=%0b exp 0/1", fifo_count, pending); end
        step();
        n_tests++; if (regWrite !== 1'b0 || pending !== 1'b0) begin n_fail++; $display("FAIL ld_done got we=%0b pend=%0b exp 0/0", regWrite, pending); end
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hBAD;
        step();
        ld_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ld_x0 got cnt=%0d exp 0", fifo_count); end
        step();
        n_tests++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL ld_x0_write got %0b exp 0", regWrite); end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(1 + k); alu_data = 32'(k + 32'h50);
            ld_valid  = 1'b1; ld_rd  = 5'(10 + k); ld_data = 32'(32'h100 + k);
            step();
            n_tests++; if (regWrite !== 1'b1 || writeReg !== 5'(1 + k) || fifo_count !== 3'(k + 1)) begin n_fail++; $display("FAIL cont_fill%0d got %0b/%0d/cnt%0d exp 1/%0d/cnt%0d", k, regWrite, writeReg, fifo_count, 1 + k, k + 1); end
        end
        n_tests++; if (ld_ready !== 1'b0 || stall_req !== 1'b1) begin n_fail++; $display("FAIL cont_full got rdy=%0b stall=%0b exp 0/1", ld_ready, stall_req); end
        alu_rd = 5'd9; ld_rd = 5'd20; ld_data = 32'hFFFF;
        step();
        n_tests++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL cont_reject got cnt=%0d exp 4", fifo_count); end
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            n_tests++; if (regWrite !== 1'b1 || writeReg !== 5'(10 + k) || writeData !== 32'(32'h100 + k) || fifo_count !== 3'(3 - k)) begin n_fail++; $display("FAIL cont_drain%0d got %0b/%0d/%0h/cnt%0d exp 1/%0d/%0h/cnt%0d", k, regWrite, writeReg, writeData, fifo_count, 10 + k, 32'h100 + k, 3 - k); end
        end
        n_tests++; if (ld_ready !== 1'b1 || stall_req !== 1'b0) begin n_fail++; $display("FAIL cont_empty got rdy=%0b stall=%0b exp 1/0", ld_ready, stall_req); end
        step();
    endtask

    task automatic test_back_to_back();
        ld_valid = 1'b1; ld_rd = 5'd21; ld_data = 32'hA1;
        step();
        ld_rd = 5'd22; ld_data = 32'hA2;
        step();
        ld_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd1 || regWrite !== 1'b1 || writeReg !== 5'd21) begin n_fail++; $display("FAIL b2b_pushpop got cnt=%0d we=%0b rd=%0d exp 1/1/21", fifo_count, regWrite, writeReg); end
        step();
        n_tests++; if (fifo_count !== 3'd0 || regWrite !== 1'b1 || writeReg !== 5'd22 || writeData !== 32'hA2) begin n_fail++; $display("FAIL b2b_second got cnt=%0d we=%0b rd=%0d d=%0h exp 0/1/22/a2", fifo_count, regWrite, writeReg, writeData); end
        step();
    endtask

    task automatic test_bypass();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h77;
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'hA;
        step();
        ld_data = 32'hB;
        step();
        ld_valid = 1'b0;
        byp_addr1 = 5'd3; byp_addr2 = 5'd0;
        #1;
`ifdef WB_BYPASS_EN
        n_tests++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hB) begin n_fail++; $display("FAIL byp_young got %0b/%0h exp 1/b", byp_hit1, byp_data1); end
        n_tests++; if (byp_hit2 !== 1'b0 || byp_data2 !== 32'h0) begin n_fail++; $display("FAIL byp_x0 got %0b/%0h exp 0/0", byp_hit2, byp_data2); end
        byp_addr2 = 5'd1;
        #1;
        n_tests++; if (byp_hit2 !== 1'b1 || byp_data2 !== 32'h77) begin n_fail++; $display("FAIL byp_outstage got %0b/%0h exp 1/77", byp_hit2, byp_data2); end
`else
        n_tests++; if (byp_hit1 !== 1'b0 || byp_data1 !== 32'h0 || byp_hit2 !== 1'b0) begin n_fail++; $display("FAIL byp_tied got %0b/%0h/%0b exp 0/0/0", byp_hit1, byp_data1, byp_hit2); end
`endif
        alu_valid = 1'b0;
        step();
        step();
        n_tests++; if (writeReg !== 5'd3 || writeData !== 32'hB || fifo_count !== 3'd0) begin n_fail++; $display("FAIL byp_drain got %0d/%0h/cnt%0d exp 3/b/cnt0", writeReg, writeData, fifo_count); end
`ifdef WB_BYPASS_EN
        n_tests++; if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hB) begin n_fail++; $display("FAIL byp_last got %0b/%0h exp 1/b", byp_hit1, byp_data1); end
`endif
        step();
        n_tests++; if (byp_hit1 !== 1'b0 || byp_data1 !== 32'h0) begin n_fail++; $display("FAIL byp_idle got %0b/%0h exp 0/0", byp_hit1, byp_data1); end
        idle();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_rd = 5'(4 + k); ld_data = 32'(32'hC0 + k);
            step();
        end
        ld_valid = 1'b0;
        n_tests++; if (fifo_count !== 3'd3 || regWrite !== 1'b1) begin n_fail++; $display("FAIL mid_queued got cnt=%0d we=%0b exp 3/1", fifo_count, regWrite); end
        #2;
        reset = 1'b0;
        alu_valid = 1'b0;
        #1;
        n_tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0 || pending !== 1'b0) begin n_fail++; $display("FAIL mid_async got we=%0b cnt=%0d pend=%0b exp 0/0/0", regWrite, fifo_count, pending); end
        n_tests++; if (writeReg !== 5'd0 || writeData !== 32'd0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_outs got %0d/%0h/rdy%0b exp 0/0/1", writeReg, writeData, ld_ready); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (regWrite !== 1'b0 || fifo_count !== 3'd0 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_stale%0d got we=%0b cnt=%0d rdy=%0b exp 0/0/1", k, regWrite, fifo_count, ld_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_contention();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
